// File: rtl/fifo_burst_writer.sv
// Burst producer for the async FIFO write port: reserves space for a whole burst, then streams it.
// Optional macro BURST_WR_TIMEOUT_EN adds a bounded wait for FIFO space (tmo_err).
module fifo_burst_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 6,
  parameter int LEN_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  burst_req,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  burst_ack,
  output logic                  burst_done,
  output logic                  len_err,
  output logic                  tmo_err,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  fifo_full,
  input  logic [CNT_WIDTH-1:0]  wr_data_count,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  ovf_err
);

  localparam int DEPTH = 2 ** (CNT_WIDTH - 1);
  localparam int CMP_W = CNT_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_reg, beat_cnt;
  logic [CNT_WIDTH-1:0] free;
  logic                 space_ok, len_bad, last_beat, tmo_hit;

  // wr_data_count lags the real occupancy, so this never overstates free space
  assign free      = CNT_WIDTH'(DEPTH) - wr_data_count;
  assign space_ok  = {{LEN_WIDTH{1'b0}}, free} >= {{CNT_WIDTH{1'b0}}, len_reg};
  assign len_bad   = {{CNT_WIDTH{1'b0}}, burst_len} > CMP_W'(DEPTH);
  assign last_beat = fifo_wr_en && (beat_cnt == LEN_WIDTH'(1));

`ifdef BURST_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  // Counter sits at zero outside WAIT_SPACE, so entry always starts a fresh count
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)                wait_cnt <= '0;
    else if (state != WAIT_SPACE) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT_SPACE) && !space_ok && (wait_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) tmo_err <= 1'b0;
    else           tmo_err <= tmo_hit;
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (burst_req && !len_bad) state_nxt = WAIT_SPACE;
      WAIT_SPACE: begin
        if (space_ok)     state_nxt = (len_reg == '0) ? IDLE : BURST;
        else if (tmo_hit) state_nxt = IDLE;
      end
      BURST:      if (last_beat) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    s_ready      = (state == BURST) && !fifo_full;
    fifo_wr_en   = s_ready && s_valid;
    fifo_wr_data = s_data;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      len_reg    <= '0;
      beat_cnt   <= '0;
      burst_ack  <= 1'b0;
      burst_done <= 1'b0;
      len_err    <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      burst_ack  <= (state == WAIT_SPACE) && space_ok;
      burst_done <= ((state == WAIT_SPACE) && space_ok && (len_reg == '0)) ||
                    ((state == BURST) && last_beat);
      len_err    <= (state == IDLE) && burst_req && len_bad;
      if ((state == IDLE) && burst_req)
        len_reg <= burst_len;
      if ((state == WAIT_SPACE) && space_ok)
        beat_cnt <= len_reg;
      else if ((state == BURST) && fifo_wr_en)
        beat_cnt <= beat_cnt - 1'b1;
      // Unreachable with a correct FIFO: a granted burst has its space reserved
      if ((state == BURST) && s_valid && fifo_full)
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: grant timing, space wait, length limits, gaps, reset, overflow flag.
module tb_fifo_burst_writer;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n = 1'b0;
  logic        burst_req = 1'b0;
  logic [7:0]  burst_len = '0;
  logic        burst_ack, burst_done, len_err, tmo_err, busy;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        fifo_full = 1'b0;
  logic [5:0]  wr_data_count = '0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        ovf_err;

  int total = 0;
  int bad = 0;

  logic        o_ack, o_done, o_lerr, o_tmo, o_busy, o_ready, o_wr, o_ovf;
  logic [31:0] o_data;

  always #5 wr_clk = ~wr_clk;

  fifo_burst_writer #(
    .DATA_WIDTH(32), .CNT_WIDTH(6), .LEN_WIDTH(8), .TIMEOUT_CYC(16)
  ) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .burst_req(burst_req), .burst_len(burst_len),
    .burst_ack(burst_ack), .burst_done(burst_done),
    .len_err(len_err), .tmo_err(tmo_err), .busy(busy),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fifo_full(fifo_full), .wr_data_count(wr_data_count),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .ovf_err(ovf_err)
  );

  // Capture outputs mid-cycle, then advance to just after the next rising edge
  task automatic step();
    @(negedge wr_clk);
    o_ack = burst_ack; o_done = burst_done; o_lerr = len_err; o_tmo = tmo_err;
    o_busy = busy; o_ready = s_ready; o_wr = fifo_wr_en; o_data = fifo_wr_data; o_ovf = ovf_err;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic request(input logic [7:0] len);
    burst_len = len;
    burst_req = 1'b1;
    step();
    burst_req = 1'b0;
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0;
    step();
    total++;
    if ({o_busy, o_ack, o_done, o_lerr, o_tmo, o_ovf, o_ready, o_wr} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000000", {o_busy, o_ack, o_done, o_lerr, o_tmo, o_ovf, o_ready, o_wr});
    end
    wr_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    wr_data_count = 6'd0;
    s_valid = 1'b1;
    request(8'd8);
    s_data = 32'hA000;
    step();
    total++;
    if ({o_busy, o_ack, o_wr} !== 3'b100) begin
      bad++; $display("FAIL basic_wait got=%b want=100", {o_busy, o_ack, o_wr});
    end
    for (int i = 0; i < 8; i++) begin
      s_data = 32'hA000 + i;
      step();
      total++;
      if ({o_wr, o_ack, o_done} !== {1'b1, (i == 0), 1'b0} || o_data !== 32'hA000 + i) begin
        bad++; $display("FAIL basic_beat%0d got wr/ack/done=%b data=%h want=%b data=%h", i, {o_wr, o_ack, o_done}, o_data, {1'b1, (i == 0), 1'b0}, 32'hA000 + i);
      end
    end
    step();
    total++;
    if ({o_done, o_busy, o_wr, o_ack} !== 4'b1000) begin
      bad++; $display("FAIL basic_done got done/busy/wr/ack=%b want=1000", {o_done, o_busy, o_wr, o_ack});
    end
    s_valid = 1'b0;
    step();
    total++;
    if ({o_done, o_busy} !== 2'b00) begin
      bad++; $display("FAIL basic_after got done/busy=%b want=00", {o_done, o_busy});
    end
  endtask

  task automatic test_wait_space();
    int n_wr;
    wr_data_count = 6'd28;
    s_valid = 1'b1;
    request(8'd8);
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({o_busy, o_ack, o_wr} !== 3'b100) begin
        bad++; $display("FAIL wait_hold%0d got busy/ack/wr=%b want=100", i, {o_busy, o_ack, o_wr});
      end
    end
    wr_data_count = 6'd24;
    step();
    total++;
    if (o_ack !== 1'b0) begin
      bad++; $display("FAIL wait_no_early_ack got=%b want=0", o_ack);
    end
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'hB000 + i;
      step();
      if (i == 0) begin
        total++;
        if (o_ack !== 1'b1) begin
          bad++; $display("FAIL wait_ack got=%b want=1", o_ack);
        end
      end
      if (o_wr === 1'b1 && o_data === 32'hB000 + i) n_wr++;
    end
    step();
    total++;
    if (n_wr !== 8 || o_done !== 1'b1) begin
      bad++; $display("FAIL wait_beats got writes=%0d done=%b want writes=8 done=1", n_wr, o_done);
    end
    s_valid = 1'b0;
    wr_data_count = 6'd0;
    step();
  endtask

  task automatic test_len_limits();
    int n_wr;
    s_valid = 1'b1;
    request(8'd33);
    step();
    total++;
    if ({o_lerr, o_busy, o_wr} !== 3'b100) begin
      bad++; $display("FAIL len33_err got lerr/busy/wr=%b want=100", {o_lerr, o_busy, o_wr});
    end
    step();
    total++;
    if ({o_lerr, o_busy, o_wr} !== 3'b000) begin
      bad++; $display("FAIL len33_after got lerr/busy/wr=%b want=000", {o_lerr, o_busy, o_wr});
    end
    request(8'd32);
    step();
    total++;
    if ({o_lerr, o_busy} !== 2'b01) begin
      bad++; $display("FAIL len32_accept got lerr/busy=%b want=01", {o_lerr, o_busy});
    end
    n_wr = 0;
    for (int i = 0; i < 32; i++) begin
      s_data = 32'hD000 + i;
      step();
      if (i == 0) begin
        total++;
        if (o_ack !== 1'b1) begin
          bad++; $display("FAIL len32_ack got=%b want=1", o_ack);
        end
      end
      if (o_wr === 1'b1 && o_data === 32'hD000 + i) n_wr++;
    end
    step();
    total++;
    if (n_wr !== 32 || o_done !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL len32_beats got writes=%0d done=%b busy=%b want 32/1/0", n_wr, o_done, o_busy);
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_len();
    s_valid = 1'b1;
    request(8'd0);
    step();
    step();
    total++;
    if ({o_ack, o_done, o_wr, o_busy} !== 4'b1100) begin
      bad++; $display("FAIL zero_len got ack/done/wr/busy=%b want=1100", {o_ack, o_done, o_wr, o_busy});
    end
    step();
    total++;
    if ({o_ack, o_done, o_wr, o_busy} !== 4'b0000) begin
      bad++; $display("FAIL zero_len_after got ack/done/wr/busy=%b want=0000", {o_ack, o_done, o_wr, o_busy});
    end
    s_valid = 1'b0;
  endtask

  task automatic test_gaps_and_reset();
    logic [6:0]  pat;
    logic [31:0] exp_d [4];
    int n_wr;
    pat = 7'b1011001;
    exp_d[0] = 32'hC000; exp_d[1] = 32'hC003; exp_d[2] = 32'hC004; exp_d[3] = 32'hC006;
    n_wr = 0;
    request(8'd4);
    step();
    for (int k = 0; k < 7; k++) begin
      s_valid = pat[k];
      s_data  = 32'hC000 + k;
      step();
      total++;
      if (o_wr !== pat[k]) begin
        bad++; $display("FAIL gap_wr%0d got=%b want=%b", k, o_wr, pat[k]);
      end
      if (o_wr === 1'b1) begin
        total++;
        if (n_wr > 3 || o_data !== exp_d[n_wr[1:0]]) begin
          bad++; $display("FAIL gap_data%0d got=%h want=%h", n_wr, o_data, exp_d[n_wr[1:0]]);
        end
        n_wr++;
      end
    end
    s_valid = 1'b0;
    step();
    total++;
    if (n_wr !== 4 || o_done !== 1'b1) begin
      bad++; $display("FAIL gap_done got writes=%0d done=%b want 4/1", n_wr, o_done);
    end
    s_valid = 1'b1;
    request(8'd4);
    step();
    step();
    step();
    wr_rst_n = 1'b0;
    #1;
    total++;
    if ({busy, burst_ack, burst_done, s_ready, fifo_wr_en, ovf_err} !== 6'b000000) begin
      bad++; $display("FAIL async_reset got=%b want=000000", {busy, burst_ack, burst_done, s_ready, fifo_wr_en, ovf_err});
    end
    step();
    wr_rst_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_wr !== 1'b0 || o_busy !== 1'b0) n_wr++;
    end
    total++;
    if (n_wr !== 0) begin
      bad++; $display("FAIL reset_abandon got active_cycles=%0d want=0", n_wr);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_ovf();
    s_valid = 1'b1;
    request(8'd2);
    step();
    fifo_full = 1'b1;
    step();
    total++;
    if ({o_ack, o_ready, o_wr, o_ovf} !== 4'b1000) begin
      bad++; $display("FAIL ovf_stall got ack/ready/wr/ovf=%b want=1000", {o_ack, o_ready, o_wr, o_ovf});
    end
    fifo_full = 1'b0;
    step();
    total++;
    if ({o_ovf, o_wr} !== 2'b11) begin
      bad++; $display("FAIL ovf_set got ovf/wr=%b want=11", {o_ovf, o_wr});
    end
    step();
    s_valid = 1'b0;
    step();
    total++;
    if ({o_ovf, o_done} !== 2'b11) begin
      bad++; $display("FAIL ovf_sticky got ovf/done=%b want=11", {o_ovf, o_done});
    end
  endtask

  task automatic test_timeout();
    int n_bad;
    wr_data_count = 6'd32;
    n_bad = 0;
    request(8'd1);
`ifdef BURST_WR_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      step();
      if ({o_busy, o_tmo, o_ack} !== 3'b100) n_bad++;
    end
    total++;
    if (n_bad !== 0) begin
      bad++; $display("FAIL tmo_wait got bad_cycles=%0d want=0", n_bad);
    end
    step();
    total++;
    if ({o_tmo, o_busy, o_ack} !== 3'b100) begin
      bad++; $display("FAIL tmo_pulse got tmo/busy/ack=%b want=100", {o_tmo, o_busy, o_ack});
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      if ({o_busy, o_tmo, o_ack, o_wr} !== 4'b1000) n_bad++;
    end
    total++;
    if (n_bad !== 0) begin
      bad++; $display("FAIL wait_forever got bad_cycles=%0d want=0", n_bad);
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_wait_space();
    test_len_limits();
    test_zero_len();
    test_gaps_and_reset();
    test_ovf();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
- Write-side producer for the async FIFO. It runs in the FIFO write clock domain and drives the FIFO write port.
- Accepts burst requests of N write-port beats. It grants a burst only when the FIFO has room for the whole burst, then streams the beats from a valid/ready source into the FIFO.
- Guarantees that a granted burst never stalls on FIFO full. The DDR3 write path can then issue a fixed-length burst without mid-burst bubbles from the FIFO.

Parameters:
- DATA_WIDTH, 32, width of one FIFO write-port beat.
- CNT_WIDTH, 6, width of FIFO wr_data_count. FIFO capacity in beats is DEPTH = 2^(CNT_WIDTH-1).
- LEN_WIDTH, 8, width of burst_len.
- TIMEOUT_CYC, 1024, wait limit in WAIT_SPACE. Used only with BURST_WR_TIMEOUT_EN.

Ports:
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  reset, asynchronous, active-low
- burst_req  in  1  request strobe; sampled only in IDLE
- burst_len  in  LEN_WIDTH  beats in the requested burst; sampled with burst_req
- burst_ack  out  1  one-cycle pulse: burst granted, space reserved
- burst_done  out  1  one-cycle pulse: last beat written
- len_err  out  1  one-cycle pulse: burst_len > DEPTH, request rejected
- tmo_err  out  1  one-cycle pulse: wait timeout (macro only; tied 0 otherwise)
- busy  out  1  state != IDLE
- s_data  in  DATA_WIDTH  source beat
- s_valid  in  1  source beat valid
- s_ready  out  1  block accepts beat
- fifo_full  in  1  FIFO full flag
- wr_data_count  in  CNT_WIDTH  FIFO occupancy in write-port beats (conservative, pointer-sync lagged)
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- ovf_err  out  1  sticky: beat offered while fifo_full in BURST; cleared only by reset

Behaviour:
- Reset: state=IDLE, len_reg=0, beat_cnt=0. burst_ack, burst_done, len_err, tmo_err, busy, ovf_err, s_ready and fifo_wr_en are all 0. Reset is asynchronous; there is no synchronous clear.
- Reset mid-burst: the burst is abandoned immediately and the remaining beats are never written. The source must re-request.
- Free-space arithmetic: free = DEPTH - wr_data_count, computed at CNT_WIDTH bits, unsigned. Because wr_data_count is conservative, free never overstates the real space.
- State IDLE:
  - On burst_req=1, latch burst_len into len_reg.
  - If burst_len > DEPTH, pulse len_err next cycle and stay IDLE.
  - Otherwise go to WAIT_SPACE.
- State WAIT_SPACE: each cycle, if free >= len_reg:
  - If len_reg==0: pulse burst_ack and burst_done together next cycle, then go to IDLE.
  - Otherwise: beat_cnt <= len_reg, burst_ack pulses next cycle, go to BURST.
- State BURST:
  - s_ready = !fifo_full, combinational.
  - fifo_wr_en = s_valid & s_ready.
  - fifo_wr_data = s_data, combinational passthrough with zero latency.
  - Each accepted beat decrements beat_cnt.
  - On the accepted beat with beat_cnt==1: go to IDLE, and burst_done pulses the next cycle.
  - If s_valid=1 while fifo_full=1, set ovf_err. This cannot occur with a correct FIFO; it is a safety net only.
- Outside BURST, s_ready=0 and fifo_wr_en=0.
- burst_ack is asserted in the first BURST cycle, so s_ready can be high in the same cycle as burst_ack.
- Timing from request to first beat:
  - burst_req sampled at edge T, space check at T+1, ack and first possible beat at T+2.
- Back-to-back bursts: minimum one IDLE cycle between bursts. The IDLE -> WAIT_SPACE gap guarantees that wr_data_count already reflects the previous burst's last beat.
- s_valid gaps inside BURST simply pause the burst; there is no timeout in BURST.
- burst_req during a non-IDLE state is ignored. It is not queued.

Optional Feature:
- BURST_WR_TIMEOUT_EN:
  - Defined: a wait counter clears on entry to WAIT_SPACE and increments each cycle there. When it reaches TIMEOUT_CYC, pulse tmo_err next cycle and return to IDLE without ack.
  - Undefined: the counter is not built, tmo_err is tied 0, and WAIT_SPACE waits indefinitely.

Test Plan:
- Defaults, empty FIFO (count=0), req len=8, s_valid held 1 -> burst_ack at T+2; 8 consecutive fifo_wr_en; burst_done one cycle after 8th beat; busy low after.
- count=28, req len=8 -> stays WAIT_SPACE, no ack; lower count to 24 -> ack 1 cycle later, 8 beats written.
- req len=33 -> len_err pulse, busy stays 0, no fifo_wr_en; req len=32 with count=0 -> accepted.
- req len=0 -> burst_ack and burst_done in same cycle, zero fifo_wr_en.
- len=4 with s_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes matching s_data order; assert wr_rst_n low after 2 beats -> all outputs 0 asynchronously, no further writes.
- With BURST_WR_TIMEOUT_EN, TIMEOUT_CYC=16, count=32, len=1 -> tmo_err pulse after 16 wait cycles, returns IDLE; without macro -> still WAIT_SPACE at cycle 100.
